// File: rtl/wb_priority_arbiter.sv
// wb_priority_arbiter: N_CH-channel writeback arbiter. Each execute unit
// owns a one-entry holding slot. The lowest-index full slot wins, unless a
// slot has waited STARVE_LIMIT cycles, in which case it is promoted. The
// winner's result and bus are registered. A NOP bus is emitted when no
// channel wins.
module wb_priority_arbiter #(
  parameter int N_CH         = 9,
  parameter int DATA_W       = 32,
  parameter int BUS_W        = 151,
  parameter int STARVE_LIMIT = 8,
  parameter logic [BUS_W-1:0] NOP_BUS = {{(BUS_W-12){1'b0}}, 12'h010},
  localparam int SEL_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [N_CH-1:0]          ch_valid_i,
  output logic [N_CH-1:0]          ch_ready_o,
  input  logic [N_CH*DATA_W-1:0]   ch_result_i,
  input  logic [N_CH*BUS_W-1:0]    ch_bus_i,
  input  logic                     stall_i,
  output logic                     p_valid_o,
  output logic [DATA_W-1:0]        p_result_o,
  output logic [BUS_W-1:0]         p_bus_o,
  output logic [N_CH-1:0]          p_grant_o,
  output logic [SEL_W-1:0]         p_sel_o,
  output logic                     starve_o
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  // Slot state
  logic [N_CH-1:0]   full_q, full_d;
  logic [7:0]        wait_q [N_CH];
  logic [7:0]        wait_d [N_CH];
  logic [DATA_W-1:0] res_q  [N_CH];
  logic [DATA_W-1:0] res_d  [N_CH];
  logic [BUS_W-1:0]  bus_q  [N_CH];
  logic [BUS_W-1:0]  bus_d  [N_CH];

  // Arbitration results
  logic [N_CH-1:0]   starved;
  logic [N_CH-1:0]   gnt;
  logic [N_CH-1:0]   cap;
  logic [SEL_W-1:0]  sel;
  logic              starve_sel;
  logic              found;

  // Output register
  logic              p_valid_q, p_valid_d;
  logic [DATA_W-1:0] p_result_q, p_result_d;
  logic [BUS_W-1:0]  p_bus_q, p_bus_d;
  logic [N_CH-1:0]   p_grant_q, p_grant_d;
  logic [SEL_W-1:0]  p_sel_q, p_sel_d;
  logic              starve_q, starve_d;

  // Grant depends only on slot state and stall, never on ch_valid_i.
  assign ch_ready_o = ~full_q | gnt;
  assign cap        = ch_valid_i & ch_ready_o;

  // Pick the lowest-index starved slot, else the lowest-index full slot.
  always_comb begin
    starved    = '0;
    gnt        = '0;
    sel        = '0;
    starve_sel = 1'b0;
    found      = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      starved[k] = full_q[k] && (wait_q[k] >= LIMIT);
    end
    if (!stall_i) begin
      if (|starved) begin
        starve_sel = 1'b1;
        for (int k = 0; k < N_CH; k++) begin
          if (starved[k] && !found) begin
            gnt[k] = 1'b1;
            sel    = SEL_W'(k);
            found  = 1'b1;
          end
        end
      end else begin
        for (int k = 0; k < N_CH; k++) begin
          if (full_q[k] && !found) begin
            gnt[k] = 1'b1;
            sel    = SEL_W'(k);
            found  = 1'b1;
          end
        end
      end
    end
  end

  // Slot capture/release and wait-counter update.
  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      full_d[k] = full_q[k];
      res_d[k]  = res_q[k];
      bus_d[k]  = bus_q[k];
      wait_d[k] = wait_q[k];
      if (cap[k]) begin
        full_d[k] = 1'b1;
        res_d[k]  = ch_result_i[k*DATA_W +: DATA_W];
        bus_d[k]  = ch_bus_i[k*BUS_W +: BUS_W];
      end else if (gnt[k]) begin
        full_d[k] = 1'b0;
      end
      // Empty slots stay at zero, so a capture during stall also starts at zero.
      if (!stall_i) begin
        if (gnt[k] || !full_q[k]) begin
          wait_d[k] = '0;
        end else if (wait_q[k] < LIMIT) begin
          wait_d[k] = wait_q[k] + 8'd1;
        end
      end
    end
  end

  // Output register next value: winner, NOP, or hold while stalled.
  always_comb begin
    p_valid_d  = p_valid_q;
    p_result_d = p_result_q;
    p_bus_d    = p_bus_q;
    p_grant_d  = p_grant_q;
    p_sel_d    = p_sel_q;
    starve_d   = starve_q;
    if (!stall_i) begin
      if (|gnt) begin
        p_valid_d  = 1'b1;
        p_result_d = res_q[sel];
        p_bus_d    = bus_q[sel];
        p_grant_d  = gnt;
        p_sel_d    = sel;
        starve_d   = starve_sel;
      end else begin
        p_valid_d  = 1'b0;
        p_result_d = '0;
        p_bus_d    = NOP_BUS;
        p_grant_d  = '0;
        p_sel_d    = '0;
        starve_d   = 1'b0;
      end
    end
  end

  // Control and output registers; reset drops pending slots and forces NOP.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      full_q     <= '0;
      for (int k = 0; k < N_CH; k++) wait_q[k] <= '0;
      p_valid_q  <= 1'b0;
      p_result_q <= '0;
      p_bus_q    <= NOP_BUS;
      p_grant_q  <= '0;
      p_sel_q    <= '0;
      starve_q   <= 1'b0;
    end else begin
      full_q     <= full_d;
      wait_q     <= wait_d;
      p_valid_q  <= p_valid_d;
      p_result_q <= p_result_d;
      p_bus_q    <= p_bus_d;
      p_grant_q  <= p_grant_d;
      p_sel_q    <= p_sel_d;
      starve_q   <= starve_d;
    end
  end

  // Slot payload registers; contents are qualified by full_q.
  always_ff @(posedge clk) begin
    res_q <= res_d;
    bus_q <= bus_d;
  end

  assign p_valid_o  = p_valid_q;
  assign p_result_o = p_result_q;
  assign p_bus_o    = p_bus_q;
  assign p_grant_o  = p_grant_q;
  assign p_sel_o    = p_sel_q;
  assign starve_o   = starve_q;

endmodule

// File: tb/tb_wb_priority_arbiter.sv
// Testbench for wb_priority_arbiter: directed vector table, hand-written
// starvation and reset sequences, and randomized traffic against a model.
module tb_wb_priority_arbiter;

  localparam int N  = 9;
  localparam int DW = 32;
  localparam int BW = 151;
  localparam int SL = 8;
  localparam int SW = 4;
  localparam logic [BW-1:0] NOP = {{(BW-12){1'b0}}, 12'h010};

  logic              clk;
  logic              reset_n;
  logic [N-1:0]      ch_valid_i;
  logic [N-1:0]      ch_ready_o;
  logic [N*DW-1:0]   ch_result_i;
  logic [N*BW-1:0]   ch_bus_i;
  logic              stall_i;
  logic              p_valid_o;
  logic [DW-1:0]     p_result_o;
  logic [BW-1:0]     p_bus_o;
  logic [N-1:0]      p_grant_o;
  logic [SW-1:0]     p_sel_o;
  logic              starve_o;

  int total = 0;
  int bad   = 0;

  wb_priority_arbiter #(
    .N_CH(N), .DATA_W(DW), .BUS_W(BW), .STARVE_LIMIT(SL)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .ch_valid_i(ch_valid_i), .ch_ready_o(ch_ready_o),
    .ch_result_i(ch_result_i), .ch_bus_i(ch_bus_i),
    .stall_i(stall_i),
    .p_valid_o(p_valid_o), .p_result_o(p_result_o), .p_bus_o(p_bus_o),
    .p_grant_o(p_grant_o), .p_sel_o(p_sel_o), .starve_o(starve_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [BW-1:0] bus_of(input logic [DW-1:0] r, input int k);
    return {r, r, r, r, 23'(k)};
  endfunction

  task automatic set_ch(input int k, input logic [DW-1:0] r, input logic [BW-1:0] b);
    ch_result_i[k*DW +: DW] = r;
    ch_bus_i[k*BW +: BW]    = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string nm, input logic v, input int sel, input logic st,
                         input logic [DW-1:0] r, input logic [BW-1:0] b);
    logic [N-1:0] g;
    g = v ? (N'(1) << sel) : '0;
    chk({nm, ".valid"},  160'(p_valid_o),  160'(v));
    chk({nm, ".result"}, 160'(p_result_o), v ? 160'(r) : 160'(0));
    chk({nm, ".bus"},    160'(p_bus_o),    v ? 160'(b) : 160'(NOP));
    chk({nm, ".grant"},  160'(p_grant_o),  160'(g));
    chk({nm, ".sel"},    160'(p_sel_o),    v ? 160'(sel) : 160'(0));
    chk({nm, ".starve"}, 160'(starve_o),   v ? 160'(st) : 160'(0));
  endtask

  // Directed vectors: inputs for one cycle, ready before the edge, output after it.
  typedef struct {
    logic [N-1:0] vld;
    logic         stall;
    logic [N-1:0] rdy;
    logic         ov;
    int           osel;
  } vec_t;

  vec_t tbl[17];

  function automatic vec_t mk(input logic [N-1:0] vld, input logic stall,
                              input logic [N-1:0] rdy, input logic ov, input int osel);
    vec_t v;
    v.vld = vld; v.stall = stall; v.rdy = rdy; v.ov = ov; v.osel = osel;
    return v;
  endfunction

  // Behavioural model state
  bit             m_full [N];
  int             m_wait [N];
  logic [DW-1:0]  m_res  [N];
  logic [BW-1:0]  m_bus  [N];
  logic           m_ov;
  int             m_osel;
  logic           m_ost;
  logic [DW-1:0]  m_ores;
  logic [BW-1:0]  m_obus;

  // Winner by the rules: oldest-starved lowest index first, else lowest full index.
  function automatic int pick();
    for (int k = 0; k < N; k++) if (m_full[k] && m_wait[k] >= SL) return k;
    for (int k = 0; k < N; k++) if (m_full[k]) return k;
    return -1;
  endfunction

  initial begin
    logic [N-1:0] rdy_exp;
    logic         r0;
    int           seq0;
    int           w;

    ch_valid_i  = '0;
    ch_result_i = '0;
    ch_bus_i    = '0;
    stall_i     = 1'b0;

    // Reset with data on every input.
    reset_n    = 1'b0;
    ch_valid_i = '1;
    for (int k = 0; k < N; k++) set_ch(k, 32'hDEAD_0000 + DW'(k), bus_of(32'hDEAD_0000 + DW'(k), k));
    tick(); tick();
    chk_out("reset", 1'b0, 0, 1'b0, '0, NOP);
    chk("reset.ready", 160'(ch_ready_o), 160'(9'h1FF));
    chk("reset.nopbus_low", 160'(p_bus_o[11:0]), 160'(12'h010));
    ch_valid_i = '0;
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Directed table.
    tbl[0]  = mk(9'h008, 1'b0, 9'h1FF, 1'b0, 0);
    tbl[1]  = mk(9'h000, 1'b0, 9'h1FF, 1'b1, 3);
    tbl[2]  = mk(9'h000, 1'b0, 9'h1FF, 1'b0, 0);
    tbl[3]  = mk(9'h021, 1'b0, 9'h1FF, 1'b0, 0);
    tbl[4]  = mk(9'h000, 1'b0, 9'h1DF, 1'b1, 0);
    tbl[5]  = mk(9'h000, 1'b0, 9'h1FF, 1'b1, 5);
    tbl[6]  = mk(9'h000, 1'b0, 9'h1FF, 1'b0, 0);
    tbl[7]  = mk(9'h010, 1'b0, 9'h1FF, 1'b0, 0);
    tbl[8]  = mk(9'h006, 1'b0, 9'h1FF, 1'b1, 4);
    for (int i = 9; i < 14; i++) tbl[i] = mk(9'h000, 1'b1, 9'h1F9, 1'b1, 4);
    tbl[14] = mk(9'h000, 1'b0, 9'h1FB, 1'b1, 1);
    tbl[15] = mk(9'h000, 1'b0, 9'h1FF, 1'b1, 2);
    tbl[16] = mk(9'h000, 1'b0, 9'h1FF, 1'b0, 0);

    for (int k = 0; k < N; k++) set_ch(k, 32'hA5A5_0000 + DW'(k), bus_of(32'hA5A5_0000 + DW'(k), k));
    for (int i = 0; i < 17; i++) begin
      ch_valid_i = tbl[i].vld;
      stall_i    = tbl[i].stall;
      #1;
      chk($sformatf("tbl%0d.ready", i), 160'(ch_ready_o), 160'(tbl[i].rdy));
      tick();
      chk_out($sformatf("tbl%0d", i), tbl[i].ov, tbl[i].osel, 1'b0,
              32'hA5A5_0000 + DW'(tbl[i].osel),
              bus_of(32'hA5A5_0000 + DW'(tbl[i].osel), tbl[i].osel));
    end
    ch_valid_i = '0;
    stall_i    = 1'b0;

    // Channel 0 streams every cycle, channel 8 presents once.
    seq0 = 0;
    for (int i = 0; i < 14; i++) begin
      ch_valid_i[0] = 1'b1;
      set_ch(0, 32'h0C00_0000 + DW'(seq0), bus_of(32'h0C00_0000 + DW'(seq0), 0));
      ch_valid_i[8] = (i == 0);
      if (i == 0) set_ch(8, 32'h8888_0008, bus_of(32'h8888_0008, 8));
      #1;
      r0 = ch_ready_o[0];
      chk($sformatf("starve%0d.ready0", i), 160'(r0), 160'(i != 9));
      tick();
      if (r0) seq0++;
      if (i == 0)
        chk_out("starve0", 1'b0, 0, 1'b0, '0, NOP);
      else if (i <= 8)
        chk_out($sformatf("starve%0d", i), 1'b1, 0, 1'b0, 32'h0C00_0000 + DW'(i-1),
                bus_of(32'h0C00_0000 + DW'(i-1), 0));
      else if (i == 9)
        chk_out("starve9", 1'b1, 8, 1'b1, 32'h8888_0008, bus_of(32'h8888_0008, 8));
      else
        chk_out($sformatf("starve%0d", i), 1'b1, 0, 1'b0, 32'h0C00_0000 + DW'(i-2),
                bus_of(32'h0C00_0000 + DW'(i-2), 0));
    end
    ch_valid_i = '0;
    tick(); tick();

    // Reset mid-stream with four slots full and a real output on p_*.
    for (int k = 0; k < N; k++) set_ch(k, 32'h5500_0000 + DW'(k), bus_of(32'h5500_0000 + DW'(k), k));
    ch_valid_i = 9'h0CC;
    tick();
    ch_valid_i = 9'h002;
    tick();
    ch_valid_i = '0;
    chk_out("prerst", 1'b1, 2, 1'b0, 32'h5500_0002, bus_of(32'h5500_0002, 2));
    #2;
    reset_n = 1'b0;
    #1;
    chk_out("midrst", 1'b0, 0, 1'b0, '0, NOP);
    chk("midrst.ready", 160'(ch_ready_o), 160'(9'h1FF));
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_out($sformatf("postrst%0d", i), 1'b0, 0, 1'b0, '0, NOP);
      chk($sformatf("postrst%0d.ready", i), 160'(ch_ready_o), 160'(9'h1FF));
    end

    // Randomized traffic against the model; DUT is empty and showing NOP.
    for (int k = 0; k < N; k++) begin
      m_full[k] = 1'b0; m_wait[k] = 0; m_res[k] = '0; m_bus[k] = '0;
    end
    m_ov = 1'b0; m_osel = 0; m_ost = 1'b0; m_ores = '0; m_obus = NOP;
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < N; k++) begin
        ch_valid_i[k] = (k < 3) ? ($urandom_range(3) != 0) : ($urandom_range(3) == 0);
        set_ch(k, $urandom, {$urandom, $urandom, $urandom, $urandom, 23'($urandom)});
      end
      stall_i = ($urandom_range(4) == 0);
      #1;
      w = stall_i ? -1 : pick();
      for (int k = 0; k < N; k++) rdy_exp[k] = !m_full[k] || (k == w);
      chk($sformatf("rnd%0d.ready", c), 160'(ch_ready_o), 160'(rdy_exp));
      // Model update for this edge.
      if (!stall_i) begin
        if (w >= 0) begin
          m_ov = 1'b1; m_osel = w; m_ost = (m_wait[w] >= SL);
          m_ores = m_res[w]; m_obus = m_bus[w];
        end else begin
          m_ov = 1'b0; m_osel = 0; m_ost = 1'b0; m_ores = '0; m_obus = NOP;
        end
        for (int k = 0; k < N; k++) begin
          if (m_full[k] && k != w) m_wait[k] = (m_wait[k] + 1 > SL) ? SL : m_wait[k] + 1;
          else m_wait[k] = 0;
          if (k == w) m_full[k] = 1'b0;
        end
      end
      for (int k = 0; k < N; k++) begin
        if (ch_valid_i[k] && rdy_exp[k]) begin
          m_full[k] = 1'b1;
          m_wait[k] = 0;
          m_res[k]  = ch_result_i[k*DW +: DW];
          m_bus[k]  = ch_bus_i[k*BW +: BW];
        end
      end
      tick();
      chk_out($sformatf("rnd%0d", c), m_ov, m_osel, m_ost, m_ores, m_obus);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_priority_arbiter.md
# wb_priority_arbiter

Parametrised writeback arbiter between the execute units (ALU, FPU, MUL, DIV, FMUL, FDIV, FADD_SUB, FSQRT, R4, …) and the writeback pipeline register. Each of `N_CH` channels has a valid/ready handshake and a one-entry holding slot. Arbitration is fixed-priority with starvation promotion, and the winner's result and pipeline bus are registered. When no unit wins, a NOP bus (debugger `inst_valid` set) is emitted.

## Interface
Parameters:
- `N_CH`, 9: number of execute-unit channels; index 0 has highest fixed priority.
- `DATA_W`, 32: result width.
- `BUS_W`, 151: pipeline-signal bus width (`exe_p_mux_bus_type` packed width).
- `STARVE_LIMIT`, 8: waiting arbitration cycles after which a channel is promoted; range 1..255.
- `NOP_BUS`, `{{BUS_W-12{1'b0}},12'h010}`: bus value driven when no grant.

Ports:
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `ch_valid_i`  in  N_CH  unit presents result.
- `ch_ready_o`  out  N_CH  slot can accept this cycle.
- `ch_result_i`  in  N_CH*DATA_W  results, channel k at bits [k*DATA_W +: DATA_W].
- `ch_bus_i`  in  N_CH*BUS_W  pipeline buses, same packing.
- `stall_i`  in  1  writeback stalled; output register must hold.
- `p_valid_o`  out  1  output holds a real instruction.
- `p_result_o`  out  DATA_W  selected result.
- `p_bus_o`  out  BUS_W  selected pipeline bus.
- `p_grant_o`  out  N_CH  one-hot channel that produced the output (0 when NOP).
- `p_sel_o`  out  max(1,$clog2(N_CH))  binary index of that channel (0 when NOP).
- `starve_o`  out  1  current output was granted via starvation promotion.

## Operation
- Per channel: `full[k]`, `result[k]`, `bus[k]`, `wait_cnt[k]` (8-bit, saturating at `STARVE_LIMIT`).
- Capture: `ch_valid_i[k] && ch_ready_o[k]` loads the slot and sets `full[k]`. `ch_ready_o[k] = !full[k] || gnt[k]`, where `gnt` depends only on `full`, `wait_cnt` and `stall_i`. There is no combinational path from `ch_valid_i`.
- Arbitration (combinational, only when `!stall_i`):
  - The starved set is `full[k] && wait_cnt[k] >= STARVE_LIMIT`.
  - If the starved set is non-empty, grant its lowest index and set starve = 1.
  - Otherwise grant the lowest-index full slot and set starve = 0.
  - At most one grant per cycle.
- On grant of k: load the output register with `result[k]`, `bus[k]`, `p_valid_o=1`, the grant and sel, and the starve flag. Clear `full[k]` unless it is recaptured the same cycle. Clear `wait_cnt[k]`.
- No full slot and `!stall_i`: output register loads `p_valid_o=0`, `p_result_o=0`, `p_bus_o=NOP_BUS`, `p_grant_o=0`, `p_sel_o=0`, `starve_o=0`.
- Wait counters: when `!stall_i`, each full, non-granted slot increments, saturating. An empty slot resets to 0. A slot captured while empty starts at 0.
- `stall_i=1`: all output registers hold, no grant occurs, counters freeze, and `ch_ready_o = !full`.

## Timing
- Reset (async assert, synchronous deassert of effect at the next edge): all `full` = 0, `wait_cnt` = 0, `p_valid_o` = 0, `p_result_o` = 0, `p_bus_o` = `NOP_BUS`, `p_grant_o` = 0, `p_sel_o` = 0, `starve_o` = 0, `ch_ready_o` = all 1.
- Latency: a result accepted at edge E0 is in its slot after E0. If granted in the next cycle, it appears on `p_*` after edge E1, i.e. 2 cycles from the presentation of `ch_valid_i`.
- Throughput: 1 output per cycle overall. A single channel sustains 1 per cycle when it is always granted (grant-and-recapture in the same cycle).
- Simultaneous grant and capture on one channel: the new data replaces the slot, `full` stays 1, and `wait_cnt` = 0.
- Reset mid-operation: pending slots are discarded and the output goes to NOP immediately.
- Starvation bound: a full slot is granted within `STARVE_LIMIT + N_CH` non-stalled cycles.

## Test plan
- Reset with data on all inputs: `p_valid_o=0`, `p_bus_o[11:0]=12'h010`, upper bus bits 0, `ch_ready_o` = all ones, `p_sel_o=0`.
- Channel 3 valid for one cycle with result `32'hA5A5_0003` → 2 cycles later `p_valid_o=1`, `p_result_o=32'hA5A5_0003`, `p_sel_o=3`, `p_grant_o=9'b000001000`, `starve_o=0`. The following cycle returns to NOP.
- Channels 0 and 5 valid in the same cycle → channel 0 output at +2, channel 5 output at +3, with `ch_ready_o[5]` low during +1.
- Channel 0 valid every cycle, channel 8 valid once, `STARVE_LIMIT=8`:
  - channel 8 waits exactly 8 arbitration cycles, then outputs with `starve_o=1`;
  - channel 0 resumes on the next cycle;
  - no channel 0 data is lost (its ready drops for one cycle).
- Slots 1 and 2 full, `stall_i` high for 5 cycles:
  - `p_*` hold their last value;
  - `ch_ready_o[1]` and `ch_ready_o[2]` are 0;
  - counters stay unchanged;
  - after release, channel 1 then channel 2 are output on consecutive cycles.
- Assert `reset_n` low mid-stream with 4 slots full → outputs go to NOP values before the next clock edge. After release no stale result appears, and all `ch_ready_o` are 1.
